// File: rtl/pci_pkg.sv
// pci_pkg: PCI command codes, master sequencer states and bus idle constants
// shared by the initiator sequencer and its bench.
package pci_pkg;

    typedef enum logic [3:0] {
        MEM_READ  = 4'b0110,
        MEM_WRITE = 4'b0111
    } pci_cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        ABORT,
        TURN
    } mst_state_e;

    localparam logic [3:0] CBE_IDLE = 4'hF;

endpackage

// File: rtl/pci_master_ctrl.sv
// pci_master_ctrl: PCI initiator sequencer turning request/write/read streams
// into FRAME_/IRDY_ bus cycles, with master abort on a missing DEVSEL_.
module pci_master_ctrl
    import pci_pkg::*;
#(
    parameter int MAX_BURST      = 16,
    parameter int DEVSEL_TIMEOUT = 5
) (
    input  logic                             clk,
    input  logic                             reset_,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [31:0]                      req_addr,
    input  logic [3:0]                       req_be,
    input  logic [$clog2(MAX_BURST+1)-1:0]   req_len,
    input  logic                             wdata_valid,
    output logic                             wdata_ready,
    input  logic [31:0]                      wdata,
    output logic                             rdata_valid,
    output logic [31:0]                      rdata,
    output logic                             done,
    output logic                             done_err,
    output logic                             FRAME_,
    output logic                             IRDY_,
    output logic [3:0]                       C_BE_,
    output logic [31:0]                      AD,
    output logic                             ad_oe,
    input  logic [31:0]                      ad_in,
    input  logic                             DEVSEL_,
    input  logic                             TRDY_
);

    localparam int LW = $clog2(MAX_BURST + 1);
    localparam int CW = $clog2(DEVSEL_TIMEOUT + 1);

    mst_state_e    state, state_n;
    logic          live, write_q, wd_v, err_q, devsel_seen;
    logic [31:0]   addr_q, wd_q;
    logic [3:0]    be_q;
    logic [LW-1:0] len_q, beats_left, fetched;
    logic [CW-1:0] abort_cnt;
    logic          irdy, xfer, last, abort_go, wd_hs, accept;

    // irdy depends on flops only, so IRDY_/FRAME_ never see an input path
    assign irdy     = (state == DATA) && (!write_q || wd_v);
    assign xfer     = irdy && !TRDY_;
    assign last     = beats_left == LW'(1);
    assign abort_go = (state == DATA) && !devsel_seen && DEVSEL_
                      && (abort_cnt == CW'(DEVSEL_TIMEOUT - 1));
    assign wd_hs    = wdata_valid && wdata_ready;
    assign accept   = (state == IDLE) && live && req_valid;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n     = state;
        req_ready   = live && (state == IDLE);
        wdata_ready = !wd_v && write_q && (state == ADDR || state == DATA) && (fetched < len_q);
        done        = state == TURN;
        done_err    = (state == TURN) && err_q;
        FRAME_      = !((state == ADDR) || ((state == DATA) && !(last && irdy)));
        IRDY_       = !(irdy || (state == ABORT));
        C_BE_       = (state == ADDR) ? 4'(write_q ? MEM_WRITE : MEM_READ) :
                      (state == DATA || state == ABORT) ? be_q : CBE_IDLE;
        AD          = ((state == ADDR) || !write_q) ? addr_q : wd_q;
        ad_oe       = (state == ADDR) || (write_q && (state == DATA || state == ABORT));
        case (state)
            IDLE:    state_n = accept ? ADDR : IDLE;
            ADDR:    state_n = DATA;
            DATA:    state_n = (xfer && last) ? TURN : abort_go ? ABORT : DATA;
            ABORT:   state_n = TURN;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            live        <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            be_q        <= CBE_IDLE;
            len_q       <= '0;
            beats_left  <= '0;
            fetched     <= '0;
            wd_q        <= '0;
            wd_v        <= 1'b0;
            err_q       <= 1'b0;
            devsel_seen <= 1'b0;
            abort_cnt   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else begin
            live        <= 1'b1;
            rdata_valid <= xfer && !write_q;
            if (xfer && !write_q) rdata <= ad_in;
            if (accept) begin
                write_q    <= req_write;
                addr_q     <= req_addr;
                be_q       <= req_be;
                len_q      <= (req_len == '0) ? LW'(1) : req_len;
                beats_left <= (req_len == '0) ? LW'(1) : req_len;
                fetched    <= '0;
                err_q      <= 1'b0;
            end
            if (state == ADDR) begin
                abort_cnt   <= '0;
                devsel_seen <= 1'b0;
            end
            if (state == DATA) begin
                if (!DEVSEL_)          devsel_seen <= 1'b1;
                else if (!devsel_seen) abort_cnt   <= abort_cnt + CW'(1);
            end
            // a word arriving on the abort edge is consumed but never driven
            if (wd_hs) begin
                fetched <= fetched + LW'(1);
                if (!abort_go) begin
                    wd_q <= wdata;
                    wd_v <= 1'b1;
                end
            end
            if (xfer) begin
                beats_left <= beats_left - LW'(1);
                wd_v       <= 1'b0;
            end
            if ((state == DATA) && (state_n == ABORT)) begin
                wd_v  <= 1'b0;
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pci_master_ctrl.sv
// tb_pci_master_ctrl: directed scenario bench for the PCI initiator sequencer;
// outputs are sampled 1 time unit after each rising edge.
module tb_pci_master_ctrl;
    logic        clk = 1'b0, reset_ = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_be = '0;
    logic [4:0]  req_len = '0;
    logic        wdata_valid = 1'b0;
    logic [31:0] wdata = '0, ad_in = '0;
    logic        DEVSEL_ = 1'b1, TRDY_ = 1'b1;
    logic        req_ready, wdata_ready, rdata_valid, done, done_err, FRAME_, IRDY_, ad_oe;
    logic [31:0] rdata, AD;
    logic [3:0]  C_BE_;

    int pass_cnt = 0;
    int total = 0;

    logic [31:0] rd_data [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    logic        trdy_pat [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int          beat_of [6] = '{0, 1, 1, 1, 2, 3};

    pci_master_ctrl dut (
        .clk(clk), .reset_(reset_),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_be(req_be), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .done_err(done_err),
        .FRAME_(FRAME_), .IRDY_(IRDY_), .C_BE_(C_BE_), .AD(AD), .ad_oe(ad_oe),
        .ad_in(ad_in), .DEVSEL_(DEVSEL_), .TRDY_(TRDY_)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        repeat (2) step();
        total++; if ({FRAME_, IRDY_, C_BE_, AD, ad_oe} !== {1'b1, 1'b1, 4'hF, 32'h0, 1'b0}) $display("FAIL reset_bus got=%h exp=%h", {FRAME_, IRDY_, C_BE_, AD, ad_oe}, {1'b1, 1'b1, 4'hF, 32'h0, 1'b0}); else pass_cnt++;
        total++; if ({req_ready, wdata_ready, rdata_valid, done, done_err} !== 5'b0) $display("FAIL reset_flags got=%b exp=00000", {req_ready, wdata_ready, rdata_valid, done, done_err}); else pass_cnt++;
        #3 reset_ = 1'b1;
        step();
        total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", req_ready); else pass_cnt++;
    endtask

    task automatic test_single_write();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1000_0000; req_be = 4'h0; req_len = 5'd1;
        step();
        req_valid = 1'b0;
        total++; if ({FRAME_, C_BE_, ad_oe, wdata_ready} !== {1'b0, 4'b0111, 1'b1, 1'b1}) $display("FAIL sw_t1_ctrl got=%b exp=0011111", {FRAME_, C_BE_, ad_oe, wdata_ready}); else pass_cnt++;
        total++; if (AD !== 32'h1000_0000) $display("FAIL sw_t1_addr got=%h exp=10000000", AD); else pass_cnt++;
        wdata_valid = 1'b1; wdata = 32'hDEAD_BEEF;
        step();
        wdata_valid = 1'b0; DEVSEL_ = 1'b0; TRDY_ = 1'b0;
        total++; if ({FRAME_, IRDY_, C_BE_} !== {1'b1, 1'b0, 4'h0}) $display("FAIL sw_t2_ctrl got=%b exp=100000", {FRAME_, IRDY_, C_BE_}); else pass_cnt++;
        total++; if (AD !== 32'hDEAD_BEEF) $display("FAIL sw_t2_data got=%h exp=deadbeef", AD); else pass_cnt++;
        step();
        DEVSEL_ = 1'b1; TRDY_ = 1'b1;
        total++; if ({done, done_err, FRAME_, IRDY_} !== 4'b1011) $display("FAIL sw_t3_done got=%b exp=1011", {done, done_err, FRAME_, IRDY_}); else pass_cnt++;
        step();
        total++; if ({done, req_ready} !== 2'b01) $display("FAIL sw_t4_idle got=%b exp=01", {done, req_ready}); else pass_cnt++;
    endtask

    task automatic test_read4();
        int n;
        n = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h2000_0040; req_be = 4'h0; req_len = 5'd4;
        step();
        req_valid = 1'b0;
        total++; if ({FRAME_, C_BE_, AD} !== {1'b0, 4'b0110, 32'h2000_0040}) $display("FAIL rd_addr_phase got=%h exp=%h", {FRAME_, C_BE_, AD}, {1'b0, 4'b0110, 32'h2000_0040}); else pass_cnt++;
        DEVSEL_ = 1'b0;
        step();
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) begin
                total++; if (rdata_valid !== !trdy_pat[c-1]) $display("FAIL rd_valid c=%0d got=%b exp=%b", c, rdata_valid, !trdy_pat[c-1]); else pass_cnt++;
                if (rdata_valid === 1'b1 && n < 4) begin
                    total++; if (rdata !== rd_data[n]) $display("FAIL rd_data beat=%0d got=%h exp=%h", n, rdata, rd_data[n]); else pass_cnt++;
                    n++;
                end
            end
            if (c < 6) begin
                total++; if ({FRAME_, IRDY_, ad_oe} !== {(beat_of[c] == 3), 1'b0, 1'b0}) $display("FAIL rd_ctrl c=%0d got=%b exp=%b00", c, {FRAME_, IRDY_, ad_oe}, (beat_of[c] == 3)); else pass_cnt++;
                TRDY_ = trdy_pat[c];
                ad_in = trdy_pat[c] ? 32'hBAD0_0000 : rd_data[beat_of[c]];
                step();
            end
        end
        total++; if ({done, done_err} !== 2'b10) $display("FAIL rd_done got=%b exp=10", {done, done_err}); else pass_cnt++;
        total++; if (n != 4) $display("FAIL rd_pulses got=%0d exp=4", n); else pass_cnt++;
        DEVSEL_ = 1'b1; TRDY_ = 1'b1;
        step();
    endtask

    task automatic test_write_gap();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h3000_0000; req_be = 4'h3; req_len = 5'd3;
        step();
        req_valid = 1'b0; wdata_valid = 1'b1; wdata = 32'hA0A0_0000;
        step();
        wdata_valid = 1'b0; DEVSEL_ = 1'b0; TRDY_ = 1'b0;
        total++; if ({FRAME_, IRDY_, AD} !== {2'b00, 32'hA0A0_0000}) $display("FAIL wg_beat1 got=%h exp=%h", {FRAME_, IRDY_, AD}, {2'b00, 32'hA0A0_0000}); else pass_cnt++;
        step();
        for (int k = 0; k < 4; k++) begin
            total++; if ({FRAME_, IRDY_} !== 2'b01) $display("FAIL wg_gap_ctrl k=%0d got=%b exp=01", k, {FRAME_, IRDY_}); else pass_cnt++;
            total++; if ($isunknown({AD, C_BE_}) || C_BE_ !== 4'h3) $display("FAIL wg_gap_bus k=%0d got=%h/%h exp=known/3", k, AD, C_BE_); else pass_cnt++;
            if (k == 3) begin wdata_valid = 1'b1; wdata = 32'hA1A1_0001; end
            step();
        end
        wdata_valid = 1'b0;
        total++; if ({FRAME_, IRDY_, AD} !== {2'b00, 32'hA1A1_0001}) $display("FAIL wg_beat2 got=%h exp=%h", {FRAME_, IRDY_, AD}, {2'b00, 32'hA1A1_0001}); else pass_cnt++;
        step();
        total++; if ({FRAME_, IRDY_, wdata_ready} !== 3'b011) $display("FAIL wg_wait3 got=%b exp=011", {FRAME_, IRDY_, wdata_ready}); else pass_cnt++;
        wdata_valid = 1'b1; wdata = 32'hA2A2_0002;
        step();
        wdata_valid = 1'b0;
        total++; if ({FRAME_, IRDY_, AD} !== {2'b10, 32'hA2A2_0002}) $display("FAIL wg_beat3 got=%h exp=%h", {FRAME_, IRDY_, AD}, {2'b10, 32'hA2A2_0002}); else pass_cnt++;
        step();
        total++; if ({done, done_err} !== 2'b10) $display("FAIL wg_done got=%b exp=10", {done, done_err}); else pass_cnt++;
        DEVSEL_ = 1'b1; TRDY_ = 1'b1;
        step();
    endtask

    task automatic test_abort();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h5000_0000; req_be = 4'hA; req_len = 5'd2;
        step();
        req_valid = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            total++; if ({FRAME_, IRDY_, done} !== 3'b000) $display("FAIL ab_data k=%0d got=%b exp=000", k, {FRAME_, IRDY_, done}); else pass_cnt++;
            step();
        end
        total++; if ({FRAME_, IRDY_, C_BE_, ad_oe, done} !== {1'b1, 1'b0, 4'hA, 1'b0, 1'b0}) $display("FAIL ab_abort got=%b exp=10101000", {FRAME_, IRDY_, C_BE_, ad_oe, done}); else pass_cnt++;
        step();
        total++; if ({done, done_err, FRAME_, IRDY_} !== 4'b1111) $display("FAIL ab_turn got=%b exp=1111", {done, done_err, FRAME_, IRDY_}); else pass_cnt++;
        step();
        total++; if ({done, req_ready} !== 2'b01) $display("FAIL ab_idle got=%b exp=01", {done, req_ready}); else pass_cnt++;
    endtask

    task automatic test_abort_vs_last();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h6000_0000; req_be = 4'h0; req_len = 5'd1;
        step();
        req_valid = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            total++; if ({FRAME_, IRDY_} !== 2'b10) $display("FAIL avl_data k=%0d got=%b exp=10", k, {FRAME_, IRDY_}); else pass_cnt++;
            if (k == 4) begin TRDY_ = 1'b0; ad_in = 32'h5A5A_5A5A; end
            step();
        end
        TRDY_ = 1'b1;
        total++; if ({done, done_err, rdata_valid} !== 3'b101) $display("FAIL avl_turn got=%b exp=101", {done, done_err, rdata_valid}); else pass_cnt++;
        total++; if (rdata !== 32'h5A5A_5A5A) $display("FAIL avl_rdata got=%h exp=5a5a5a5a", rdata); else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        int a1, a2, d1, d2;
        logic [31:0] a2_addr;
        a1 = -1; a2 = -1; d1 = -1; d2 = -1; a2_addr = '0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h7000_0000; req_be = 4'h0; req_len = 5'd2;
        wdata_valid = 1'b1; wdata = 32'hCAFE_0000; DEVSEL_ = 1'b0; TRDY_ = 1'b0;
        for (int c = 0; c < 14; c++) begin
            step();
            if (!FRAME_ && C_BE_ === 4'b0111) begin
                if (a1 < 0) begin
                    a1 = c; req_addr = 32'h7000_0100;
                end else if (a2 < 0) begin
                    a2 = c; a2_addr = AD; req_valid = 1'b0;
                end
            end
            if (done === 1'b1) begin
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
        end
        wdata_valid = 1'b0; DEVSEL_ = 1'b1; TRDY_ = 1'b1;
        total++; if (a1 != 0 || d1 != 4) $display("FAIL b2b_first got=addr@%0d done@%0d exp=addr@0 done@4", a1, d1); else pass_cnt++;
        total++; if (a2 != 6) $display("FAIL b2b_second_addr got=%0d exp=6", a2); else pass_cnt++;
        total++; if (d2 != 10) $display("FAIL b2b_second_done got=%0d exp=10", d2); else pass_cnt++;
        total++; if (a2_addr !== 32'h7000_0100) $display("FAIL b2b_addr2 got=%h exp=70000100", a2_addr); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4000_0000; req_be = 4'h0; req_len = 5'd4;
        step();
        req_valid = 1'b0; wdata_valid = 1'b1; wdata = 32'hB0B0_0000; DEVSEL_ = 1'b0; TRDY_ = 1'b0;
        step();
        wdata_valid = 1'b0;
        step();
        wdata_valid = 1'b1; wdata = 32'hB1B1_0001;
        step();
        wdata_valid = 1'b0;
        total++; if ({FRAME_, IRDY_} !== 2'b00) $display("FAIL rm_beat2 got=%b exp=00", {FRAME_, IRDY_}); else pass_cnt++;
        #2 reset_ = 1'b0;
        #1;
        total++; if ({FRAME_, IRDY_, C_BE_, AD, ad_oe} !== {1'b1, 1'b1, 4'hF, 32'h0, 1'b0}) $display("FAIL rm_async_bus got=%h exp=%h", {FRAME_, IRDY_, C_BE_, AD, ad_oe}, {1'b1, 1'b1, 4'hF, 32'h0, 1'b0}); else pass_cnt++;
        total++; if ({req_ready, wdata_ready, done} !== 3'b000) $display("FAIL rm_async_flags got=%b exp=000", {req_ready, wdata_ready, done}); else pass_cnt++;
        DEVSEL_ = 1'b1; TRDY_ = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            total++; if (done !== 1'b0) $display("FAIL rm_no_done k=%0d got=%b exp=0", k, done); else pass_cnt++;
        end
        #3 reset_ = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            total++; if ({done, FRAME_} !== 2'b01) $display("FAIL rm_after k=%0d got=%b exp=01", k, {done, FRAME_}); else pass_cnt++;
        end
        total++; if (req_ready !== 1'b1) $display("FAIL rm_ready got=%b exp=1", req_ready); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read4();
        test_write_gap();
        test_abort();
        test_abort_vs_last();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/pci_master_ctrl.md
# pci_master_ctrl

PCI initiator sequencer. It converts simple request, write-data and read-data streams into PCI bus cycles on `FRAME_`, `IRDY_`, `AD` and `C_BE_`, and samples `DEVSEL_` and `TRDY_` from the target. It sits directly upstream of the PCI protocol property checker and drives the signals that checker observes. Every bus output is glitch-free and free of unknowns whenever the protocol requires a known value.

## Interface
- `MAX_BURST`, default 16: maximum number of data phases per request.
- `DEVSEL_TIMEOUT`, default 5: number of data-phase cycles without `DEVSEL_` before a master abort.
- `clk` in 1: rising-edge clock.
- `reset_` in 1: asynchronous, active-low reset.
- `req_valid`/`req_ready` in/out 1: request handshake.
- `req_write` in 1: 1 selects Memory Write (`C_BE_`=0111), 0 selects Memory Read (`C_BE_`=0110).
- `req_addr` in 32: address placed on `AD` during the address phase.
- `req_be` in 4: active-low byte enables, used for every data phase.
- `req_len` in $clog2(MAX_BURST+1): number of beats, 1..MAX_BURST; 0 is treated as 1.
- `wdata_valid`/`wdata_ready` in/out 1, `wdata` in 32: write-data stream.
- `rdata_valid` out 1, `rdata` out 32: read-data beats, no backpressure.
- `done` out 1, `done_err` out 1: one-cycle completion pulse; `done_err`=1 signals a master abort.
- `FRAME_`, `IRDY_` out 1: PCI control outputs.
- `C_BE_` out 4, `AD` out 32, `ad_oe` out 1: bus drive values plus the `AD` output enable.
- `ad_in` in 32: resolved `AD` bus, used for reads.
- `DEVSEL_`, `TRDY_` in 1: target responses.

## Operation
- States: IDLE, ADDR, DATA, ABORT, TURN.
- **IDLE**
  - `req_ready`=1, `FRAME_`=`IRDY_`=1, `ad_oe`=0.
  - On `req_valid`, latch the request, load `beats_left`=`req_len`, then go to ADDR.
- **ADDR** (exactly one cycle)
  - `FRAME_`=0, `AD`=`req_addr`, `C_BE_`=command, `ad_oe`=1.
  - Next state is DATA; clear the abort counter.
- **Write-data holding register** (`wd_q` with valid flag `wd_v`)
  - `wdata_ready` = !`wd_v` && write && state∈{ADDR, DATA} && `fetched`<len.
- **DATA**
  - `C_BE_` = `req_be`.
  - `IRDY_` = !(read || `wd_v`). It is a function of flops only; no input-to-output path.
  - Writes: `AD` = `wd_q`, `ad_oe`=1. Reads: `ad_oe`=0.
  - `FRAME_` = 1 exactly when `beats_left`==1 && `IRDY_`==0. It is never 1 while `IRDY_`=1 in DATA.
  - Once `IRDY_`=0 it holds until the beat transfers.
- **Beat transfer**: a beat transfers at any clock edge in DATA where `IRDY_`=0 && `TRDY_`=0.
  - Decrement `beats_left` and clear `wd_v`.
  - Reads: register `rdata`=`ad_in` and pulse `rdata_valid` in the next cycle.
  - Last beat: go to TURN.
- **Master abort**
  - The abort counter increments on every DATA cycle while `DEVSEL_`=1 and is frozen once `DEVSEL_`=0 is seen.
  - When it reaches `DEVSEL_TIMEOUT`, go to ABORT.
- **ABORT** (one cycle)
  - `FRAME_`=1, `IRDY_`=0, `AD` holds its last value, `C_BE_`=`req_be`, `ad_oe` unchanged.
  - Next state is TURN with the error flag set.
  - Any held `wd_q` is discarded.
- **TURN** (one cycle)
  - `FRAME_`=`IRDY_`=1, `ad_oe`=0.
  - `done`=1, `done_err`=error flag.
  - Next state is IDLE.
- **Not supported**: `STOP_`, retry and disconnect. A target may only insert wait states.

## Timing
- **Reset**: all bus outputs are deasserted asynchronously.
  - `FRAME_`=`IRDY_`=1, `C_BE_`=4'hF, `AD`=0, `ad_oe`=0.
  - `req_ready`=0, `wdata_ready`=0, `rdata_valid`=0, `done`=0, `done_err`=0.
  - State=IDLE; `req_ready` rises in the first cycle after reset release.
- **Registered outputs**: every output is registered or decoded from registers only.
- **Request accepted at edge T0**:
  - ADDR occupies cycle T1.
  - The first data phase starts in T2.
  - Earliest write transfer is at the end of T2, provided `wdata_valid` was seen in T1.
  - TURN occurs in T3, with `done` in T3.
  - IDLE is T4; the next ADDR is no earlier than T5.
- **Reset mid-operation**: the bus is released immediately and no `done` pulse is generated.
- **Abort and last beat on the same edge**: if the abort counter reaches its limit on the same edge as the last beat transfers, the transfer wins and `done_err`=0.

## Structure
- Package `pci_pkg`:
  - `pci_cmd_e` with MEM_READ=4'b0110 and MEM_WRITE=4'b0111.
  - `mst_state_e`.
  - `CBE_IDLE`=4'hF.
- Single module, no sub-modules. The abort counter and beat counter are inline.

## Test plan
- **Single write**: addr 0x1000_0000, be 4'h0, len 1, wdata 0xDEADBEEF, with `DEVSEL_`/`TRDY_`=0 from T2.
  - T1: `FRAME_`=0, `AD`=0x10000000, `C_BE_`=0111.
  - T2: `FRAME_`=1, `IRDY_`=0, `AD`=0xDEADBEEF.
  - T3: `done`=1, `done_err`=0.
- **Four-beat read** with `TRDY_` held high for 2 cycles on beat 2.
  - Exactly 4 `rdata_valid` pulses, each with the matching `ad_in` values.
  - `FRAME_` rises only in the beat-4 phase.
- **Write with a 3-cycle `wdata_valid` gap** before beat 2.
  - `IRDY_`=1 during the gap.
  - `FRAME_` stays 0 and `AD`/`C_BE_` are never X while `FRAME_`=0.
- **Master abort**: `DEVSEL_` never asserted.
  - After 5 DATA cycles, ABORT drives `FRAME_`=1 and `IRDY_`=0.
  - TURN follows with `done_err`=1.
- **Reset mid-burst**: assert `reset_`=0 asynchronously during beat 2 of a 4-beat write.
  - Outputs return to their reset values before the next edge.
  - No `done` pulse is generated.
- **Back-to-back requests**: `req_valid` held high across two len-2 writes.
  - The second ADDR follows TURN of the first after exactly one IDLE cycle.
